// File: rtl/omok_pkg.sv
// Shared OMOK definitions: board geometry, cursor width, put FSM states,
// direction/button indices and a cursor step helper. Also used by the board
// and display blocks.
package omok_pkg;

  localparam int MAP_DIM = 10;
  localparam int CELLS   = MAP_DIM * MAP_DIM;
  localparam int POS_W   = 8;
  localparam int IDX_W   = $clog2(CELLS);

  localparam logic [POS_W-1:0] HOME_POS = 8'd44;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } put_state_e;

  // Direction indices double as priority order (lower index wins).
  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;
  localparam int         NUM_DIR   = 4;

  localparam int BTN_PUT  = 4;
  localparam int BTN_UNDO = 5;
  localparam int NUM_BTN  = 6;

  // One cursor step in the given direction; stays put at the board edge.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                                input logic [1:0]       dir);
    int p;
    int row;
    int col;
    p   = int'(pos);
    row = p / MAP_DIM;
    col = p % MAP_DIM;
    step_pos = pos;
    case (dir)
      DIR_RIGHT: if (col != MAP_DIM - 1) step_pos = POS_W'(p + 1);
      DIR_LEFT:  if (col != 0)           step_pos = POS_W'(p - 1);
      DIR_UP:    if (row != 0)           step_pos = POS_W'(p - MAP_DIM);
      DIR_DOWN:  if (row != MAP_DIM - 1) step_pos = POS_W'(p + MAP_DIM);
      default:   step_pos = pos;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, consecutive-cycle debounce counter,
// debounced level and a one-cycle pulse on its rising edge.
module btn_debounce #(
  parameter int DB_W     = 20,
  parameter int DB_LIMIT = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [DB_W-1:0] LIMIT_M1 = DB_W'(DB_LIMIT - 1);

  logic [1:0]      sync_q;
  logic            stable_q, stable_d;
  logic            rise_q, rise_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Count cycles the synced input disagrees with the accepted level; flip on the last one.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LIMIT_M1) begin
      cnt_d    = '0;
      stable_d = ~stable_q;
      rise_d   = ~stable_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/omok_input_ctrl.sv
// OMOK input front end: debounced buttons -> bounded cursor moves, put request
// with valid/ready handshake, put reject pulse and undo pulse.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat on direction buttons.
//
// Put FSM:
//   state   | meaning
//   ST_IDLE | no request pending; put presses are checked against the board
//   ST_REQ  | put_valid high, put_pos frozen until put_ready is sampled
module omok_input_ctrl
  import omok_pkg::*;
#(
  parameter int DB_W          = 20,
  parameter int DB_LIMIT      = 500000,
  parameter int REPEAT_DELAY  = 16500000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_put,
  input  logic             btn_undo,
  input  logic [CELLS-1:0] board_state,
  input  logic             game_over,
  output logic [POS_W-1:0] cur_pos,
  output logic             put_valid,
  output logic [POS_W-1:0] put_pos,
  input  logic             put_ready,
  output logic             put_reject,
  output logic             undo_pulse
);

  logic [NUM_BTN-1:0] btn_raw, db_level, db_rise;
  logic [NUM_DIR-1:0] rep_ev, mv_ev;

  put_state_e       state_q, state_d;
  logic [POS_W-1:0] cur_pos_q, cur_pos_d;
  logic [POS_W-1:0] put_pos_q, put_pos_d;
  logic             put_reject_q, put_reject_d;
  logic [1:0]       dir_sel;
  logic             occupied;

  assign btn_raw = {btn_undo, btn_put, btn_down, btn_up, btn_left, btn_right};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DB_W    (DB_W),
      .DB_LIMIT(DB_LIMIT)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_raw[i]),
      .level_o(db_level[i]),
      .rise_o (db_rise[i])
    );
  end

`ifdef AUTO_REPEAT_EN
  localparam int               REP_W         = $clog2(REPEAT_DELAY + 1);
  localparam logic [REP_W-1:0] REP_DELAY_M1  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_M1 = REP_W'(REPEAT_PERIOD - 1);

  // Binding = {held, dir}: the highest-priority direction currently held.
  logic [2:0]       bind_now, bind_q;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             unused_lvl;

  assign unused_lvl = ^db_level[BTN_UNDO:BTN_PUT];

  // Shared repeat timer: reload on binding change, fire and reload at terminal count.
  always_comb begin
    bind_now = 3'b000;
    if (db_level[DIR_RIGHT])     bind_now = {1'b1, DIR_RIGHT};
    else if (db_level[DIR_LEFT]) bind_now = {1'b1, DIR_LEFT};
    else if (db_level[DIR_UP])   bind_now = {1'b1, DIR_UP};
    else if (db_level[DIR_DOWN]) bind_now = {1'b1, DIR_DOWN};

    rep_ev    = '0;
    rep_cnt_d = rep_cnt_q - 1'b1;
    if (bind_now != bind_q) begin
      rep_cnt_d = REP_DELAY_M1;
    end else if (rep_cnt_q == '0) begin
      rep_cnt_d = REP_PERIOD_M1;
      if (bind_now[2]) rep_ev[bind_now[1:0]] = 1'b1;
    end
  end

  // Repeat binding and timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bind_q    <= 3'b000;
      rep_cnt_q <= '0;
    end else begin
      bind_q    <= bind_now;
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  // Repeat timing has no meaning without the repeat logic; levels are not needed either.
  localparam int unused_rep_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_lvl;
  assign unused_lvl = ^db_level;
  assign rep_ev     = '0;
`endif

  assign mv_ev    = db_rise[NUM_DIR-1:0] | rep_ev;
  assign occupied = board_state[cur_pos_q[IDX_W-1:0]];

  // Pick one direction by priority and step the cursor unless a put is pending.
  always_comb begin
    dir_sel = DIR_DOWN;
    if (mv_ev[DIR_RIGHT])     dir_sel = DIR_RIGHT;
    else if (mv_ev[DIR_LEFT]) dir_sel = DIR_LEFT;
    else if (mv_ev[DIR_UP])   dir_sel = DIR_UP;

    cur_pos_d = cur_pos_q;
    if ((|mv_ev) && (state_q != ST_REQ)) cur_pos_d = step_pos(cur_pos_q, dir_sel);
  end

  // Put FSM next state: request on a free cell, reject on occupied or game over.
  always_comb begin
    state_d      = state_q;
    put_pos_d    = put_pos_q;
    put_reject_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (db_rise[BTN_PUT]) begin
          if (!occupied && !game_over) begin
            state_d   = ST_REQ;
            put_pos_d = cur_pos_q;
          end else begin
            put_reject_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (put_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Cursor and put FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_pos_q    <= HOME_POS;
      put_pos_q    <= '0;
      put_reject_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_pos_q    <= cur_pos_d;
      put_pos_q    <= put_pos_d;
      put_reject_q <= put_reject_d;
    end
  end

  assign cur_pos    = cur_pos_q;
  assign put_valid  = (state_q == ST_REQ);
  assign put_pos    = put_pos_q;
  assign put_reject = put_reject_q;
  assign undo_pulse = db_rise[BTN_UNDO];

endmodule

// File: tb/tb_omok_input_ctrl.sv
// Bench for omok_input_ctrl with DB_LIMIT=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_omok_input_ctrl;

  localparam int LIM = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  raw = '0;  // 0 right, 1 left, 2 up, 3 down, 4 put, 5 undo
  logic [99:0] board_state = '0;
  logic        game_over = 1'b0;
  logic        put_ready = 1'b0;
  logic [7:0]  cur_pos, put_pos;
  logic        put_valid, put_reject, undo_pulse;

  int checks = 0;
  int errors = 0;
  int rej_cnt = 0;
  int undo_cnt = 0;
  int r0, u0;

  always #5 clk = ~clk;

  omok_input_ctrl #(
    .DB_W         (20),
    .DB_LIMIT     (LIM),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_left   (raw[1]),
    .btn_right  (raw[0]),
    .btn_up     (raw[2]),
    .btn_down   (raw[3]),
    .btn_put    (raw[4]),
    .btn_undo   (raw[5]),
    .board_state(board_state),
    .game_over  (game_over),
    .cur_pos    (cur_pos),
    .put_valid  (put_valid),
    .put_pos    (put_pos),
    .put_ready  (put_ready),
    .put_reject (put_reject),
    .undo_pulse (undo_pulse)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounce as run-length: a level change is accepted after LIM consecutive
  // synced cycles that disagree with it. Events are visible in the cycle after.
  logic m_s1[6], m_s2[6], m_stab[6], m_ev[6];
  int   m_run[6];
  int   m_pos, m_ppos;
  logic m_valid, m_rej;
  int   m_bind_last, m_age;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 6; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0; m_ev[b] = 0; m_run[b] = 0;
      end
      m_pos = 44; m_ppos = 0; m_valid = 0; m_rej = 0;
      m_bind_last = 4; m_age = 0;
    end else begin
      logic req[4];
      int   op, bind_now, age, row, col;
      logic ov;
      for (int d = 0; d < 4; d++) req[d] = m_ev[d];
`ifdef AUTO_REPEAT_EN
      bind_now = 4;
      for (int d = 3; d >= 0; d--) if (m_stab[d]) bind_now = d;
      age = (bind_now != m_bind_last) ? 0 : m_age + 1;
      if (bind_now != 4 && age >= RD && ((age - RD) % RP) == 0) req[bind_now] = 1;
      m_bind_last = bind_now;
      m_age = age;
`else
      bind_now = 4;
      age = 0;
`endif
      op = m_pos;
      ov = m_valid;
      row = op / 10;
      col = op % 10;
      if (!ov) begin
        if (req[0])      begin if (col != 9) m_pos = op + 1;  end
        else if (req[1]) begin if (col != 0) m_pos = op - 1;  end
        else if (req[2]) begin if (row != 0) m_pos = op - 10; end
        else if (req[3]) begin if (row != 9) m_pos = op + 10; end
      end
      m_rej = 0;
      if (!ov) begin
        if (m_ev[4]) begin
          if (!board_state[op] && !game_over) begin
            m_valid = 1; m_ppos = op;
          end else m_rej = 1;
        end
      end else if (put_ready) m_valid = 0;
      for (int b = 0; b < 6; b++) begin
        m_ev[b] = 0;
        if (m_s2[b] != m_stab[b]) begin
          m_run[b]++;
          if (m_run[b] == LIM) begin
            m_stab[b] = ~m_stab[b];
            m_ev[b] = m_stab[b];
            m_run[b] = 0;
          end
        end else m_run[b] = 0;
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("cur_pos", cur_pos, m_pos);
      check("put_valid", put_valid, m_valid);
      check("put_pos", put_pos, m_ppos);
      check("put_reject", put_reject, m_rej);
      check("undo_pulse", undo_pulse, m_ev[5]);
      rej_cnt  += put_reject;
      undo_cnt += undo_pulse;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input int b, input int hold);
    raw[b] = 1'b1;
    repeat (hold) tick();
    raw[b] = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_cur_pos", cur_pos, 44);
    check("reset_put_valid", put_valid, 0);
    check("reset_put_pos", put_pos, 0);

    press(0, 10);
    check("right_once", cur_pos, 45);
    press(1, 2);
    check("glitch_left", cur_pos, 45);

    for (int i = 0; i < 4; i++) press(0, 8);
    check("reach_col9", cur_pos, 49);
    press(0, 8);
    check("right_edge", cur_pos, 49);

    for (int i = 0; i < 4; i++) press(2, 8);
    for (int i = 0; i < 5; i++) press(1, 8);
    check("reach_4", cur_pos, 4);
    press(2, 8);
    check("up_edge", cur_pos, 4);
    for (int i = 0; i < 10; i++) press(3, 8);
    check("down_stop", cur_pos, 94);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_home", cur_pos, 44);

    raw[0] = 1'b1; raw[2] = 1'b1;
    repeat (8) tick();
    raw = '0;
    repeat (10) tick();
    check("simul_right_up", cur_pos, 45);
    press(1, 8);

    r0 = rej_cnt;
    press(4, 8);
    check("req_valid", put_valid, 1);
    check("req_pos", put_pos, 44);
    press(0, 8);
    check("blocked_move", cur_pos, 44);
    press(4, 8);
    check("put_in_req_no_reject", rej_cnt - r0, 0);
    check("still_valid", put_valid, 1);
    put_ready = 1'b1;
    tick();
    put_ready = 1'b0;
    check("accepted", put_valid, 0);

    board_state[44] = 1'b1;
    r0 = rej_cnt;
    press(4, 8);
    check("reject_occupied", rej_cnt - r0, 1);
    check("occupied_no_req", put_valid, 0);

    board_state[44] = 1'b0;
    game_over = 1'b1;
    r0 = rej_cnt;
    u0 = undo_cnt;
    press(4, 8);
    check("reject_game_over", rej_cnt - r0, 1);
    check("game_over_no_req", put_valid, 0);
    press(5, 8);
    check("undo_once", undo_cnt - u0, 1);
    game_over = 1'b0;

    put_ready = 1'b1;
    repeat (4) tick();
    put_ready = 1'b0;
    check("ready_idle_ignored", put_valid, 0);

    press(0, 8);
    press(4, 8);
    check("req2_valid", put_valid, 1);
    check("req2_pos", put_pos, 45);
    rst = 1'b1;
    #1;
    check("midreq_rst_valid", put_valid, 0);
    check("midreq_rst_pos", cur_pos, 44);
    tick();
    rst = 1'b0;
    tick();

`ifdef AUTO_REPEAT_EN
    for (int i = 0; i < 4; i++) press(2, 8);
    check("rep_start", cur_pos, 4);
    press(3, 100);
    check("rep_down_stop", cur_pos, 94);
`endif

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/omok_input_ctrl.md
Name: omok_input_ctrl

Overview:
Input-side front end of the OMOK game. It turns six raw, bouncy push-buttons into game events: a bounded cursor position, and a put request with a valid/ready handshake toward the board-state owner. It also emits an undo pulse. It feeds the board/state logic, which in turn drives the TFT display path.

Parameters:
MAP_DIM, 10, playable grid dimension; positions 0..MAP_DIM*MAP_DIM-1, row-major.
HOME_POS, 44, cursor position after reset.
DB_W, 20, debounce counter width.
DB_LIMIT, 500000, consecutive stable cycles needed to accept a level change (~15 ms at 33 MHz).
REPEAT_DELAY, 16500000, hold time before the first auto-repeat (used only with AUTO_REPEAT_EN).
REPEAT_PERIOD, 5000000, auto-repeat interval (used only with AUTO_REPEAT_EN).

Ports:
clk  in  1  system/pixel clock
rst  in  1  reset; asynchronous, active-high
btn_left, btn_right, btn_up, btn_down  in  1 each  raw asynchronous buttons, active-high
btn_put  in  1  raw put button
btn_undo  in  1  raw undo button
board_state  in  MAP_DIM*MAP_DIM  occupancy map; bit k=1 means cell k is occupied
game_over  in  1  level; suppresses new put requests
cur_pos  out  8  current cursor cell
put_valid  out  1  put request pending
put_pos  out  8  cell requested; stable while put_valid=1
put_ready  in  1  board accepts the request when put_valid & put_ready
put_reject  out  1  one-cycle pulse: put pressed on an occupied cell or during game_over
undo_pulse  out  1  one-cycle pulse per debounced undo press

Behaviour:
- Reset (async assert, sync release): cur_pos=HOME_POS; put_valid=0; put_pos=0; put_reject=0; undo_pulse=0. All synchronizers, debounced levels and counters are cleared to 0. Reset mid-handshake drops the pending put.
- Per button: 2-flop synchronizer, then debounce. The counter resets whenever the synced level equals the stable level. It increments otherwise, and when it reaches DB_LIMIT-1 the stable level flips. A press event is the rising edge of the stable level, one cycle wide.
- Latency from a clean raw edge to the event pulse: 2 + DB_LIMIT cycles (±1). Bounces shorter than DB_LIMIT cycles produce no event.
- Cursor moves, with row=cur_pos/MAP_DIM and col=cur_pos%MAP_DIM:
  - right: +1 only if col≠MAP_DIM-1
  - left: -1 only if col≠0
  - up: -MAP_DIM only if row≠0
  - down: +MAP_DIM only if row≠MAP_DIM-1
  - At an edge the move is ignored. No wrap-around.
- Simultaneous direction events in the same cycle: priority right>left>up>down. Only one move is applied; the others are discarded.
- Cursor moves are blocked (discarded) while put_valid=1. cur_pos updates the cycle after the event.
- Put FSM, states IDLE and REQ:
  - IDLE, put event, board_state[cur_pos]=0 and game_over=0: go to REQ, put_valid=1, put_pos=cur_pos.
  - IDLE, put event, occupied or game_over=1: stay in IDLE, put_reject=1 for one cycle.
  - REQ: hold put_valid and put_pos until put_ready=1 is sampled. Then return to IDLE with put_valid=0 next cycle.
  - REQ, further put events: ignored, no reject.
  - put_ready while in IDLE: ignored.
  - Occupancy is checked only at request time. A change in board_state during REQ does not cancel the request.
- Undo event: undo_pulse=1 for one cycle, independent of the put FSM and game_over.
- The same event never produces more than one action.

Optional Feature:
AUTO_REPEAT_EN:
- Defined: while a direction's stable level stays 1, a repeat counter (own width, sized for REPEAT_DELAY) generates an extra move event after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles. It stops on release. There is one shared repeat counter, bound to the highest-priority held direction; it restarts when that binding changes. Edge and blocking rules apply unchanged.
- Undefined: one move per press. No repeat logic is synthesized and the REPEAT_* parameters are unused.

Decomposition:
- Shared package omok_pkg: MAP_DIM, HOME_POS, POS_W=8, put FSM state enum (ST_IDLE, ST_REQ), direction index constants (DIR_RIGHT..DIR_DOWN). This package is also used by the board and display blocks.
- Sub-module btn_debounce (synchronizer + counter + stable level + rise pulse; parameters DB_W and DB_LIMIT), instantiated six times.

Test Plan:
(All with DB_LIMIT=4 and, where repeat is tested, REPEAT_DELAY=20 and REPEAT_PERIOD=8.)
- Reset then btn_right held 10 cycles → exactly one move, cur_pos 44→45; a 2-cycle glitch on btn_left → cur_pos unchanged.
- From cur_pos=49 (col 9), press right → stays 49. From 4 (row 0), press up → stays 4. Press down ×9 from 4 → stops at 94.
- btn_right and btn_up rising in the same cycle from 44 → cur_pos=45 only.
- Put on empty 44 with put_ready=0 for 5 cycles → put_valid=1 and put_pos=44 held. A right press meanwhile → cur_pos stays 44. put_ready=1 → put_valid=0 next cycle.
- board_state[44]=1, press put → put_reject one-cycle pulse, put_valid stays 0. Same with game_over=1 on an empty cell.
- AUTO_REPEAT_EN defined, hold down from 4 for ~60 cycles → moves at press, +20, +28, +36… (debounce latency added), stopping at 94. Assert rst mid-REQ → put_valid=0, cur_pos=44 immediately.
